// File: rtl/fetch_pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pipe_ctrl_if
//  Purpose  : Bundles the signals between the fetch controller, the hazard
//             unit, instruction memory and the ID stage.
//             master modport = fetch controller view.
//             slave  modport = environment view (hazard unit, imem, ID).
//  Signals  : stall, flush, branch_taken, branch_target, jr, jr_target,
//             imem_addr, imem_rdata, imem_valid, pc_ID, pc_plus4_ID,
//             instr_ID, valid_ID, id_ex_bubble
//             (+ stall_cycles, flush_count, wait_cycles when
//             FETCH_PERF_CNT_EN is defined)
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_pipe_ctrl_if;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] pc_ID;
    logic [31:0] pc_plus4_ID;
    logic [31:0] instr_ID;
    logic        valid_ID;
    logic        id_ex_bubble;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
    logic [31:0] wait_cycles;
`endif

    modport master (
`ifdef FETCH_PERF_CNT_EN
        output stall_cycles, flush_count, wait_cycles,
`endif
        input  stall, flush, branch_taken, branch_target, jr, jr_target,
        input  imem_rdata, imem_valid,
        output imem_addr, pc_ID, pc_plus4_ID, instr_ID, valid_ID, id_ex_bubble
    );

    modport slave (
`ifdef FETCH_PERF_CNT_EN
        input  stall_cycles, flush_count, wait_cycles,
`endif
        output stall, flush, branch_taken, branch_target, jr, jr_target,
        output imem_rdata, imem_valid,
        input  imem_addr, pc_ID, pc_plus4_ID, instr_ID, valid_ID, id_ex_bubble
    );
endinterface
`default_nettype wire

// File: rtl/fetch_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pipe_ctrl
//  Purpose  : Owns the program counter and the IF/ID register. Applies
//             load-use stalls, branch/JR redirect flushes and instruction
//             memory wait states, and drives the ID/EX bubble select.
//  Ports    : clk  - system clock, rising edge
//             rst  - asynchronous active-high reset
//             bus  - fetch_pipe_ctrl_if.master (hazard unit, imem, ID stage)
//  Params   : RESET_PC  - PC loaded on reset
//             NOP_INSTR - encoding placed in IF/ID on flush or bubble
//             PC_STEP   - byte increment per sequential fetch
//  Options  : FETCH_PERF_CNT_EN - adds saturating stall_cycles, flush_count
//             and wait_cycles counters to the interface.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_pipe_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = 32'd4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fetch_pipe_ctrl_if.master  bus
);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pc_id;
    logic [31:0] r_pc_plus4_id;
    logic [31:0] r_instr_id;
    logic        r_valid_id;

    logic [31:0] w_pc_seq;
    logic [31:0] w_redirect_pc;

    assign w_pc_seq      = r_pc + PC_STEP;   // 32-bit modulo wrap is intended
    assign w_redirect_pc = bus.branch_taken ? bus.branch_target : bus.jr_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_pc          <= RESET_PC;
            r_pc_id       <= 32'h0000_0000;
            r_pc_plus4_id <= 32'h0000_0000;
            r_instr_id    <= NOP_INSTR;
            r_valid_id    <= 1'b0;
        end else if (bus.stall) begin
            // Hold everything; any returned data is refetched after the stall.
            // A concurrent flush is dropped: its operand is stale and the
            // hazard unit re-raises it once the stall clears.
            r_state <= r_state;
        end else if (bus.flush) begin
            r_pc       <= w_redirect_pc;
            r_instr_id <= NOP_INSTR;
            r_valid_id <= 1'b0;
            r_state    <= S_RUN;
        end else if (!bus.imem_valid) begin
            // IF/ID already holds a bubble while in WAIT, so it is only
            // written on the RUN->WAIT transition.
            if (r_state == S_RUN) begin
                r_instr_id <= NOP_INSTR;
                r_valid_id <= 1'b0;
            end
            r_state <= S_WAIT;
        end else begin
            r_instr_id    <= bus.imem_rdata;
            r_pc_id       <= r_pc;
            r_pc_plus4_id <= w_pc_seq;
            r_valid_id    <= 1'b1;
            r_pc          <= w_pc_seq;
            r_state       <= S_RUN;
        end
    end

    assign bus.imem_addr    = r_pc;
    assign bus.pc_ID        = r_pc_id;
    assign bus.pc_plus4_ID  = r_pc_plus4_id;
    assign bus.instr_ID     = r_instr_id;
    assign bus.valid_ID     = r_valid_id;
    // Both a stall and an accepted flush must inject a zero-control bubble
    // into ID/EX in the same cycle; forced low while reset is held.
    assign bus.id_ex_bubble = !rst && (bus.stall || bus.flush);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;
    logic [31:0] r_wait_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= 32'h0000_0000;
            r_flush_count  <= 32'h0000_0000;
            r_wait_cycles  <= 32'h0000_0000;
        end else begin
            if (bus.stall) begin
                if (r_stall_cycles != 32'hFFFF_FFFF)
                    r_stall_cycles <= r_stall_cycles + 32'd1;
            end else if (bus.flush) begin
                if (r_flush_count != 32'hFFFF_FFFF)
                    r_flush_count <= r_flush_count + 32'd1;
            end else if (!bus.imem_valid) begin
                if (r_wait_cycles != 32'hFFFF_FFFF)
                    r_wait_cycles <= r_wait_cycles + 32'd1;
            end
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_count  = r_flush_count;
    assign bus.wait_cycles  = r_wait_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_pipe_ctrl
//  Purpose  : Self-checking bench for fetch_pipe_ctrl. Directed scenarios
//             followed by randomized traffic checked against a behavioural
//             model of the fetch stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pipe_ctrl;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_NOP      = 32'h0000_0000;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    // behavioural model of the fetch stage
    logic [31:0] m_pc;
    logic [31:0] m_pc_id;
    logic [31:0] m_pc4_id;
    logic [31:0] m_instr;
    logic        m_valid;
    logic [31:0] m_stall_cnt;
    logic [31:0] m_flush_cnt;
    logic [31:0] m_wait_cnt;

    fetch_pipe_ctrl_if bus ();

    fetch_pipe_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic s, input logic f, input logic bt,
                         input logic [31:0] btgt, input logic j,
                         input logic [31:0] jtgt, input logic v,
                         input logic [31:0] rd);
        bus.stall         = s;
        bus.flush         = f;
        bus.branch_taken  = bt;
        bus.branch_target = btgt;
        bus.jr            = j;
        bus.jr_target     = jtgt;
        bus.imem_valid    = v;
        bus.imem_rdata    = rd;
        #1;
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    // Advance one clock; the model follows the stage rules for the inputs
    // currently applied. Returns at posedge+1.
    task automatic tick();
        logic [31:0] n_pc, n_pc_id, n_pc4, n_instr;
        logic        n_valid;
        n_pc = m_pc; n_pc_id = m_pc_id; n_pc4 = m_pc4_id;
        n_instr = m_instr; n_valid = m_valid;
        if (bus.stall) begin
            m_stall_cnt = sat_inc(m_stall_cnt);
        end else if (bus.flush) begin
            n_pc    = bus.branch_taken ? bus.branch_target : bus.jr_target;
            n_instr = C_NOP;
            n_valid = 1'b0;
            m_flush_cnt = sat_inc(m_flush_cnt);
        end else if (!bus.imem_valid) begin
            n_instr = C_NOP;
            n_valid = 1'b0;
            m_wait_cnt = sat_inc(m_wait_cnt);
        end else begin
            n_instr = bus.imem_rdata;
            n_pc_id = m_pc;
            n_pc4   = m_pc + 32'd4;
            n_valid = 1'b1;
            n_pc    = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_pc_id = n_pc_id; m_pc4_id = n_pc4;
        m_instr = n_instr; m_valid = n_valid;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        rst = 1'b0;
        m_pc = C_RESET_PC; m_pc_id = 0; m_pc4_id = 0;
        m_instr = C_NOP; m_valid = 0;
        m_stall_cnt = 0; m_flush_cnt = 0; m_wait_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 1, 32'h0000_0100, 0, 0, 1, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        vectors++;
        if (bus.imem_addr !== C_RESET_PC) begin miscompares++;
            $display("FAIL reset_pc: got %h expected %h", bus.imem_addr, C_RESET_PC); end
        vectors++;
        if (bus.valid_ID !== 1'b0 || bus.instr_ID !== C_NOP) begin miscompares++;
            $display("FAIL reset_ifid: got valid=%b instr=%h expected valid=0 instr=%h",
                     bus.valid_ID, bus.instr_ID, C_NOP); end
        vectors++;
        if (bus.pc_ID !== 32'h0 || bus.pc_plus4_ID !== 32'h0) begin miscompares++;
            $display("FAIL reset_pcid: got pc_ID=%h pc_plus4_ID=%h expected 0/0",
                     bus.pc_ID, bus.pc_plus4_ID); end
        vectors++;
        if (bus.id_ex_bubble !== 1'b0) begin miscompares++;
            $display("FAIL reset_bubble: got %b expected 0", bus.id_ex_bubble); end
`ifdef FETCH_PERF_CNT_EN
        vectors++;
        if (bus.stall_cycles !== 0 || bus.flush_count !== 0 || bus.wait_cycles !== 0) begin
            miscompares++;
            $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0",
                     bus.stall_cycles, bus.flush_count, bus.wait_cycles); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] rd [3];
        rd[0] = 32'hAAAA_0001; rd[1] = 32'hBBBB_0002; rd[2] = 32'hCCCC_0003;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, rd[i]);
            vectors++;
            if (bus.imem_addr !== 32'(i * 4)) begin miscompares++;
                $display("FAIL seq_addr%0d: got %h expected %h", i, bus.imem_addr, 32'(i * 4)); end
            tick();
            vectors++;
            if (bus.instr_ID !== rd[i] || bus.valid_ID !== 1'b1) begin miscompares++;
                $display("FAIL seq_instr%0d: got %h/%b expected %h/1", i, bus.instr_ID,
                         bus.valid_ID, rd[i]); end
            vectors++;
            if (bus.pc_ID !== 32'(i * 4) || bus.pc_plus4_ID !== 32'(i * 4 + 4)) begin
                miscompares++;
                $display("FAIL seq_pcid%0d: got %h/%h expected %h/%h", i, bus.pc_ID,
                         bus.pc_plus4_ID, 32'(i * 4), 32'(i * 4 + 4)); end
        end
        vectors++;
        if (bus.imem_addr !== 32'h0000_000C) begin miscompares++;
            $display("FAIL seq_addr3: got %h expected 0000000c", bus.imem_addr); end
    endtask

    task automatic test_stall();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 32'hAAAA_0001); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 32'hBBBB_0002); tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 0, 0, 1, 32'hFFFF_0000);
            vectors++;
            if (bus.id_ex_bubble !== 1'b1) begin miscompares++;
                $display("FAIL stall_bubble%0d: got %b expected 1", i, bus.id_ex_bubble); end
            tick();
            vectors++;
            if (bus.imem_addr !== 32'h8 || bus.instr_ID !== 32'hBBBB_0002) begin miscompares++;
                $display("FAIL stall_hold%0d: got pc=%h instr=%h expected 00000008/bbbb0002",
                         i, bus.imem_addr, bus.instr_ID); end
        end
        drive(0, 0, 0, 0, 0, 0, 1, 32'hCCCC_0003); tick();
        vectors++;
        if (bus.instr_ID !== 32'hCCCC_0003 || bus.pc_ID !== 32'h8 || bus.imem_addr !== 32'hC) begin
            miscompares++;
            $display("FAIL stall_resume: got instr=%h pc_ID=%h pc=%h expected cccc0003/8/c",
                     bus.instr_ID, bus.pc_ID, bus.imem_addr); end
    endtask

    task automatic test_flush_branch();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h1111_1111); tick();
        // branch_taken wins over a concurrent jr
        drive(0, 1, 1, 32'h0000_0100, 1, 32'h0000_0300, 1, 32'h2222_2222);
        vectors++;
        if (bus.id_ex_bubble !== 1'b1) begin miscompares++;
            $display("FAIL flush_bubble: got %b expected 1", bus.id_ex_bubble); end
        tick();
        vectors++;
        if (bus.imem_addr !== 32'h100 || bus.valid_ID !== 1'b0 || bus.instr_ID !== C_NOP) begin
            miscompares++;
            $display("FAIL flush_redirect: got pc=%h valid=%b instr=%h expected 100/0/%h",
                     bus.imem_addr, bus.valid_ID, bus.instr_ID, C_NOP); end
        drive(0, 0, 0, 0, 0, 0, 1, 32'h3333_3333); tick();
        vectors++;
        if (bus.instr_ID !== 32'h3333_3333 || bus.pc_ID !== 32'h100 || bus.valid_ID !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_target_fetch: got %h/%h/%b expected 33333333/100/1",
                     bus.instr_ID, bus.pc_ID, bus.valid_ID); end
    endtask

    task automatic test_stall_flush();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h1111_1111); tick();
        drive(1, 1, 0, 0, 1, 32'h0000_0200, 1, 32'h2222_2222); tick();
        vectors++;
        if (bus.imem_addr !== 32'h4 || bus.instr_ID !== 32'h1111_1111) begin miscompares++;
            $display("FAIL stallflush_ignored: got pc=%h instr=%h expected 4/11111111",
                     bus.imem_addr, bus.instr_ID); end
        drive(0, 1, 0, 0, 1, 32'h0000_0200, 1, 32'h2222_2222); tick();
        vectors++;
        if (bus.imem_addr !== 32'h200 || bus.valid_ID !== 1'b0) begin miscompares++;
            $display("FAIL jr_redirect: got pc=%h valid=%b expected 200/0",
                     bus.imem_addr, bus.valid_ID); end
    endtask

    task automatic test_wait();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h1111_1111); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 32'h9999_9999);
            vectors++;
            if (bus.id_ex_bubble !== 1'b0) begin miscompares++;
                $display("FAIL wait_bubble%0d: got %b expected 0", i, bus.id_ex_bubble); end
            tick();
            vectors++;
            if (bus.imem_addr !== 32'h4 || bus.valid_ID !== 1'b0 || bus.instr_ID !== C_NOP) begin
                miscompares++;
                $display("FAIL wait_hold%0d: got pc=%h valid=%b instr=%h expected 4/0/%h",
                         i, bus.imem_addr, bus.valid_ID, bus.instr_ID, C_NOP); end
        end
        drive(0, 0, 0, 0, 0, 0, 1, 32'h4444_4444); tick();
        vectors++;
        if (bus.instr_ID !== 32'h4444_4444 || bus.pc_ID !== 32'h4 || bus.imem_addr !== 32'h8) begin
            miscompares++;
            $display("FAIL wait_capture: got %h/%h/%h expected 44444444/4/8",
                     bus.instr_ID, bus.pc_ID, bus.imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        vectors++;
        if (bus.wait_cycles !== 32'd3) begin miscompares++;
            $display("FAIL wait_counter: got %0d expected 3", bus.wait_cycles); end
`endif
    endtask

    task automatic test_wrap();
        do_reset();
        drive(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h5555_5555); tick();
        vectors++;
        if (bus.imem_addr !== 32'h0 || bus.pc_ID !== 32'hFFFF_FFFC || bus.pc_plus4_ID !== 32'h0) begin
            miscompares++;
            $display("FAIL pc_wrap: got pc=%h pc_ID=%h pc4=%h expected 0/fffffffc/0",
                     bus.imem_addr, bus.pc_ID, bus.pc_plus4_ID); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        drive(0, 1, 0, 0, 1, 32'h0000_0040, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h6666_6666); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick(); tick();
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.imem_addr !== C_RESET_PC || bus.valid_ID !== 1'b0) begin miscompares++;
            $display("FAIL reset_mid_wait: got pc=%h valid=%b expected %h/0",
                     bus.imem_addr, bus.valid_ID, C_RESET_PC); end
        rst = 1'b0;
        m_pc = C_RESET_PC; m_pc_id = 0; m_pc4_id = 0; m_instr = C_NOP; m_valid = 0;
        drive(0, 0, 0, 0, 0, 0, 1, 32'h7777_7777); tick();
        vectors++;
        if (bus.instr_ID !== 32'h7777_7777 || bus.pc_ID !== C_RESET_PC) begin miscompares++;
            $display("FAIL after_reset_fetch: got %h/%h expected 77777777/%h",
                     bus.instr_ID, bus.pc_ID, C_RESET_PC); end
    endtask

    task automatic test_random();
        logic        s, f, bt, j, v;
        logic [31:0] btgt, jtgt;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            s    = ($urandom_range(0, 7) == 0);
            f    = ($urandom_range(0, 5) == 0);
            bt   = $urandom_range(0, 1);
            j    = $urandom_range(0, 1);
            v    = ($urandom_range(0, 3) != 0);
            btgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : {$urandom_range(0, 65535), 2'b00};
            jtgt = $urandom();
            drive(s, f, bt, btgt, j, jtgt, v, $urandom());
            vectors++;
            if (bus.id_ex_bubble !== (s | f)) begin miscompares++;
                $display("FAIL rnd_bubble@%0d: got %b expected %b", n, bus.id_ex_bubble, s | f); end
            vectors++;
            if (bus.imem_addr !== m_pc) begin miscompares++;
                $display("FAIL rnd_addr@%0d: got %h expected %h", n, bus.imem_addr, m_pc); end
            tick();
            vectors++;
            if (bus.valid_ID !== m_valid || bus.instr_ID !== m_instr) begin miscompares++;
                $display("FAIL rnd_ifid@%0d: got %b/%h expected %b/%h", n, bus.valid_ID,
                         bus.instr_ID, m_valid, m_instr); end
            if (m_valid) begin
                vectors++;
                if (bus.pc_ID !== m_pc_id || bus.pc_plus4_ID !== m_pc4_id) begin miscompares++;
                    $display("FAIL rnd_pcid@%0d: got %h/%h expected %h/%h", n, bus.pc_ID,
                             bus.pc_plus4_ID, m_pc_id, m_pc4_id); end
            end
`ifdef FETCH_PERF_CNT_EN
            vectors++;
            if (bus.stall_cycles !== m_stall_cnt || bus.flush_count !== m_flush_cnt ||
                bus.wait_cycles !== m_wait_cnt) begin miscompares++;
                $display("FAIL rnd_counters@%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", n,
                         bus.stall_cycles, bus.flush_count, bus.wait_cycles,
                         m_stall_cnt, m_flush_cnt, m_wait_cnt); end
`endif
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_flush_branch();
        test_stall_flush();
        test_wait();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
